// File: rtl/oven_cook_sequencer_pkg.sv
// Shared constants for the oven sequencer: state encoding, timer step and
// front-panel input indices.
package oven_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_COOK  = ST_COOK,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } state_t;

    // Seconds added/removed by one up/dn command on the timer datapath.
    localparam int STEP_SECS = 5;

    localparam int KEY_START  = 0;
    localparam int KEY_STOP   = 1;
    localparam int KEY_UP     = 2;
    localparam int KEY_DN     = 3;
    localparam int KEY_DOOR   = 4;
    localparam int NUM_INPUTS = 5;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oven_cook_sequencer_if.sv
// Board/datapath bundle of the oven sequencer: raw keys and door in, timer
// command pulses and actuator drives out.
interface oven_cook_sequencer_if;

    logic       btn_start_n;
    logic       btn_stop_n;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic       door_open;
    logic       tmr_zero;

    logic       tmr_inc5;
    logic       tmr_dec5;
    logic       tmr_tick;
    logic       tmr_clear;
    logic       heater_on;
    logic       lamp_on;
    logic       beep;
    logic [1:0] state_o;

    modport master (
        input  btn_start_n, btn_stop_n, btn_up_n, btn_dn_n, door_open, tmr_zero,
        output tmr_inc5, tmr_dec5, tmr_tick, tmr_clear, heater_on, lamp_on, beep, state_o
    );

    modport slave (
        output btn_start_n, btn_stop_n, btn_up_n, btn_dn_n, door_open, tmr_zero,
        input  tmr_inc5, tmr_dec5, tmr_tick, tmr_clear, heater_on, lamp_on, beep, state_o
    );

endinterface

// File: rtl/oven_cook_sequencer_debounce.sv
// One front-panel input: 2-FF synchronizer, stability counter, and either a
// 1-cycle press pulse (EDGE_OUT=1) or the debounced level (EDGE_OUT=0).
module oven_key_debounce
    import oven_pkg::*;
#(
    parameter int DEB_CYCLES = 500_000,
    parameter bit EDGE_OUT   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_sig
);

    localparam int CW = cnt_w(DEB_CYCLES);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_out;
    logic [CW-1:0] r_cnt;

    logic          w_done;
    logic          w_take;
    logic          w_stable_nxt;
    logic          w_rise;

    // A new level is accepted once the synced input has differed from the
    // accepted level for DEB_CYCLES consecutive samples.
    assign w_done       = (r_cnt == CW'(DEB_CYCLES - 1));
    assign w_take       = (r_s2 != r_stable) && w_done;
    assign w_stable_nxt = w_take ? r_s2 : r_stable;
    assign w_rise       = w_take && r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_out    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1     <= i_raw;
            r_s2     <= r_s1;
            r_stable <= w_stable_nxt;
            r_out    <= EDGE_OUT ? w_rise : w_stable_nxt;
            if ((r_s2 == r_stable) || w_done)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sig = r_out;

endmodule

// File: rtl/oven_cook_sequencer.sv
// Oven control FSM: debounced keys/door, 1 s tick prescaler, timer command
// pulses, heater/lamp/beeper. BEEP_REPEAT_EN selects the repeating alarm.
module oven_cook_sequencer
    import oven_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int BEEP_SECS  = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    oven_cook_sequencer_if.master  bus
);

    localparam int PW       = cnt_w(TICK_DIV);
    localparam int BEEP_LEN = BEEP_SECS * TICK_DIV;
    localparam int HALF     = TICK_DIV / 2;
    localparam int BW       = cnt_w(BEEP_LEN);

    logic [NUM_INPUTS-1:0] w_raw;
    logic [NUM_INPUTS-1:0] w_sig;

    assign w_raw[KEY_START] = ~bus.btn_start_n;
    assign w_raw[KEY_STOP]  = ~bus.btn_stop_n;
    assign w_raw[KEY_UP]    = ~bus.btn_up_n;
    assign w_raw[KEY_DN]    = ~bus.btn_dn_n;
    assign w_raw[KEY_DOOR]  = bus.door_open;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        oven_key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .EDGE_OUT   (g != KEY_DOOR)
        ) u_deb (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_raw   (w_raw[g]),
            .o_sig   (w_sig[g])
        );
    end

    state_t        r_state;
    state_t        w_nxt;
    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_bcnt;
    logic          r_door_q;
    logic          r_inc5;
    logic          r_dec5;
    logic          r_tick;
    logic          r_clear;
    logic          r_heater;
    logic          r_lamp;
    logic          r_beep;

    logic w_stop;
    logic w_start;
    logic w_up;
    logic w_dn;
    logic w_any_key;
    logic w_door;
    logic w_door_rise;
    logic w_inc5;
    logic w_dec5;
    logic w_clear;
    logic w_presc_clr;
    logic w_wrap;
    logic w_cook_stay;
    logic w_enter_done;

    // Same-cycle events resolve stop > start > up > dn; losers are dropped.
    assign w_stop      = w_sig[KEY_STOP];
    assign w_start     = w_sig[KEY_START] & ~w_stop;
    assign w_up        = w_sig[KEY_UP] & ~w_sig[KEY_STOP] & ~w_sig[KEY_START];
    assign w_dn        = w_sig[KEY_DN] & ~w_sig[KEY_STOP] & ~w_sig[KEY_START] & ~w_sig[KEY_UP];
    assign w_any_key   = w_sig[KEY_START] | w_sig[KEY_STOP] | w_sig[KEY_UP] | w_sig[KEY_DN];
    assign w_door      = w_sig[KEY_DOOR];
    assign w_door_rise = w_door & ~r_door_q;

    always_comb begin
        w_nxt       = r_state;
        w_inc5      = 1'b0;
        w_dec5      = 1'b0;
        w_clear     = 1'b0;
        w_presc_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_stop) begin
                    w_clear = 1'b1;
                end else if (w_start) begin
                    if (!w_door && !bus.tmr_zero) begin
                        w_nxt       = S_COOK;
                        w_presc_clr = 1'b1;
                    end
                end else if (w_up) begin
                    w_inc5 = 1'b1;
                end else if (w_dn) begin
                    w_dec5 = !bus.tmr_zero;
                end
            end
            S_COOK: begin
                // Reaching zero outranks a stop or door opening in the same cycle.
                if (bus.tmr_zero)
                    w_nxt = S_DONE;
                else if (w_stop || w_door)
                    w_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_stop) begin
                    w_clear = 1'b1;
                    w_nxt   = S_IDLE;
                end else if (w_start && !w_door) begin
                    w_nxt = S_COOK;
                end
            end
            S_DONE: begin
                if (w_any_key || w_door_rise)
                    w_nxt = S_IDLE;
`ifndef BEEP_REPEAT_EN
                else if (r_bcnt == BW'(BEEP_LEN - 1))
                    w_nxt = S_IDLE;
`endif
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    assign w_wrap       = (r_presc == PW'(TICK_DIV - 1));
    assign w_cook_stay  = (r_state == S_COOK) && (w_nxt == S_COOK);
    assign w_enter_done = (w_nxt == S_DONE) && (r_state != S_DONE);

`ifdef BEEP_REPEAT_EN
    logic w_half_wrap;
    assign w_half_wrap = (r_bcnt == BW'(HALF - 1));
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_bcnt   <= '0;
            r_door_q <= 1'b0;
            r_inc5   <= 1'b0;
            r_dec5   <= 1'b0;
            r_tick   <= 1'b0;
            r_clear  <= 1'b0;
            r_heater <= 1'b0;
            r_lamp   <= 1'b0;
            r_beep   <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_door_q <= w_door;
            r_inc5   <= w_inc5;
            r_dec5   <= w_dec5;
            r_clear  <= w_clear;
            r_tick   <= w_cook_stay && w_wrap;
            r_heater <= (w_nxt == S_COOK);
            r_lamp   <= (w_nxt == S_COOK) || (w_nxt == S_DONE) || w_door;

            // Prescaler only advances on full COOK cycles, so PAUSE keeps the tick phase.
            if (w_presc_clr || w_enter_done)
                r_presc <= '0;
            else if (w_cook_stay)
                r_presc <= w_wrap ? '0 : r_presc + 1'b1;

            if (r_state != S_DONE)
                r_bcnt <= '0;
`ifdef BEEP_REPEAT_EN
            else
                r_bcnt <= w_half_wrap ? '0 : r_bcnt + 1'b1;
`else
            else
                r_bcnt <= r_bcnt + 1'b1;
`endif

            if (w_nxt != S_DONE)
                r_beep <= 1'b0;
            else if (r_state != S_DONE)
                r_beep <= 1'b1;
`ifdef BEEP_REPEAT_EN
            else if (w_half_wrap)
                r_beep <= ~r_beep;
`endif
        end
    end

    assign bus.tmr_inc5  = r_inc5;
    assign bus.tmr_dec5  = r_dec5;
    assign bus.tmr_tick  = r_tick;
    assign bus.tmr_clear = r_clear;
    assign bus.heater_on = r_heater;
    assign bus.lamp_on   = r_lamp;
    assign bus.beep      = r_beep;
    assign bus.state_o   = r_state;

endmodule

// File: tb/tb_oven_cook_sequencer.sv
// Directed bench for oven_cook_sequencer with TICK_DIV=10, DEB_CYCLES=4,
// BEEP_SECS=2; define BEEP_REPEAT_EN to exercise the repeating alarm.
module tb_oven_cook_sequencer;
    import oven_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    oven_cook_sequencer_if bus();

    oven_cook_sequencer #(
        .TICK_DIV   (10),
        .DEB_CYCLES (4),
        .BEEP_SECS  (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse counters and pulse-shape violation counters, sampled on negedge.
    int c_inc = 0, c_dec = 0, c_tick = 0, c_clr = 0;
    int width_viol = 0, excl_viol = 0;
    logic [3:0] w_cmd;
    logic [3:0] prev_cmd = 4'b0;
    assign w_cmd = {bus.tmr_inc5, bus.tmr_dec5, bus.tmr_tick, bus.tmr_clear};

    always @(negedge clk) begin
        if ($countones(w_cmd) > 1) excl_viol <= excl_viol + 1;
        if (|(w_cmd & prev_cmd))   width_viol <= width_viol + 1;
        if (w_cmd[3] && !prev_cmd[3]) c_inc  <= c_inc + 1;
        if (w_cmd[2] && !prev_cmd[2]) c_dec  <= c_dec + 1;
        if (w_cmd[1] && !prev_cmd[1]) c_tick <= c_tick + 1;
        if (w_cmd[0] && !prev_cmd[0]) c_clr  <= c_clr + 1;
        prev_cmd <= w_cmd;
    end

    task automatic drive_key(input int k, input logic v);
        case (k)
            KEY_START: bus.btn_start_n = v;
            KEY_STOP:  bus.btn_stop_n  = v;
            KEY_UP:    bus.btn_up_n    = v;
            default:   bus.btn_dn_n    = v;
        endcase
    endtask

    task automatic press(input int k);
        drive_key(k, 1'b0);
        repeat (10) @(negedge clk);
        drive_key(k, 1'b1);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state_o === s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.tmr_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.tmr_inc5, bus.tmr_dec5, bus.tmr_tick, bus.tmr_clear,
                bus.heater_on, bus.lamp_on, bus.beep, bus.state_o, 1'b0};
        n_tests++;
        if (outs !== 10'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0", outs);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        outs = {bus.tmr_inc5, bus.tmr_dec5, bus.tmr_tick, bus.tmr_clear,
                bus.heater_on, bus.lamp_on, bus.beep, bus.state_o, 1'b0};
        n_tests++;
        if (outs !== 10'd0) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want 0", outs);
        end
    endtask

    task automatic test_idle_keys();
        int i0, d0, t0, l0;
        i0 = c_inc; d0 = c_dec; t0 = c_tick; l0 = c_clr;
        bus.tmr_zero = 1'b0;
        repeat (3) press(KEY_UP);
        press(KEY_DN);
        n_tests++;
        if (c_inc - i0 !== 3) begin n_fail++; $display("FAIL idle_inc5_count: got %0d want 3", c_inc - i0); end
        n_tests++;
        if (c_dec - d0 !== 1) begin n_fail++; $display("FAIL idle_dec5_count: got %0d want 1", c_dec - d0); end
        n_tests++;
        if ((c_tick - t0) + (c_clr - l0) !== 0) begin
            n_fail++; $display("FAIL idle_stray_cmds: got %0d want 0", (c_tick - t0) + (c_clr - l0));
        end
        n_tests++;
        if (bus.state_o !== ST_IDLE) begin n_fail++; $display("FAIL idle_state: got %0d want 0", bus.state_o); end

        // stop and up in the same cycle: only the clear survives
        i0 = c_inc; l0 = c_clr;
        bus.btn_stop_n = 1'b0; bus.btn_up_n = 1'b0;
        repeat (10) @(negedge clk);
        bus.btn_stop_n = 1'b1; bus.btn_up_n = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++;
        if (c_clr - l0 !== 1) begin n_fail++; $display("FAIL prio_stop_clear: got %0d want 1", c_clr - l0); end
        n_tests++;
        if (c_inc - i0 !== 0) begin n_fail++; $display("FAIL prio_up_dropped: got %0d want 0", c_inc - i0); end

        bus.tmr_zero = 1'b1;
        d0 = c_dec;
        press(KEY_DN);
        n_tests++;
        if (c_dec - d0 !== 0) begin n_fail++; $display("FAIL dn_at_zero: got %0d want 0", c_dec - d0); end
        bus.tmr_zero = 1'b0;
    endtask

    task automatic test_cook_ticks();
        bit ok;
        int n, i0;
        bus.tmr_zero = 1'b0;
        bus.btn_start_n = 1'b0;
        wait_state(ST_COOK, 20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL cook_entry: got state %0d want 1", bus.state_o); end
        n_tests++;
        if ({bus.heater_on, bus.lamp_on} !== 2'b11) begin
            n_fail++; $display("FAIL cook_heater_lamp: got %b want 11", {bus.heater_on, bus.lamp_on});
        end
        wait_tick(30, n);
        n_tests++;
        if (n !== 10) begin n_fail++; $display("FAIL first_tick: got %0d want 10", n); end
        bus.btn_start_n = 1'b1;
        wait_tick(30, n);
        n_tests++;
        if (n !== 10) begin n_fail++; $display("FAIL tick_period: got %0d want 10", n); end
        i0 = c_inc;
        press(KEY_UP);
        n_tests++;
        if (c_inc - i0 !== 0 || bus.state_o !== ST_COOK) begin
            n_fail++; $display("FAIL cook_up_ignored: got inc %0d state %0d want 0 1", c_inc - i0, bus.state_o);
        end
    endtask

    task automatic test_door_pause();
        int n, i0;
        bit ok;
        wait_tick(20, n);
        n_tests++;
        if (n < 0) begin n_fail++; $display("FAIL pre_door_tick: got none want tick"); end
        bus.door_open = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.heater_on !== 1'b1) begin n = i; break; end
        end
        n_tests++;
        if (n !== 7) begin n_fail++; $display("FAIL door_heater_off: got %0d want 7", n); end
        n_tests++;
        if (bus.state_o !== ST_PAUSE || bus.lamp_on !== 1'b1) begin
            n_fail++; $display("FAIL door_pause: got state %0d lamp %b want 2 1", bus.state_o, bus.lamp_on);
        end
        i0 = c_inc;
        press(KEY_START);
        press(KEY_UP);
        n_tests++;
        if (bus.state_o !== ST_PAUSE || c_inc - i0 !== 0) begin
            n_fail++; $display("FAIL pause_ignores: got state %0d inc %0d want 2 0", bus.state_o, c_inc - i0);
        end
        bus.door_open = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (bus.lamp_on !== 1'b0) begin n_fail++; $display("FAIL pause_lamp_closed: got %b want 0", bus.lamp_on); end
        bus.btn_start_n = 1'b0;
        wait_state(ST_COOK, 20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL resume_cook: got state %0d want 1", bus.state_o); end
        // 6 cook cycles elapsed before the pause, so 4 remain in this second
        wait_tick(20, n);
        n_tests++;
        if (n !== 4) begin n_fail++; $display("FAIL resume_phase: got %0d want 4", n); end
        bus.btn_start_n = 1'b1;
    endtask

    task automatic enter_done_stop_zero();
        bus.btn_stop_n = 1'b0;
        repeat (6) @(negedge clk);
        bus.tmr_zero = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.state_o !== ST_DONE) begin n_fail++; $display("FAIL zero_beats_stop: got %0d want 3", bus.state_o); end
        n_tests++;
        if ({bus.beep, bus.heater_on, bus.lamp_on} !== 3'b101) begin
            n_fail++; $display("FAIL done_outputs: got %b want 101", {bus.beep, bus.heater_on, bus.lamp_on});
        end
    endtask

`ifndef BEEP_REPEAT_EN
    task automatic test_done_beep();
        int n;
        enter_done_stop_zero();
        n = 0;
        while (bus.beep === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (n !== 20) begin n_fail++; $display("FAIL beep_length: got %0d want 20", n); end
        n_tests++;
        if (bus.state_o !== ST_IDLE) begin n_fail++; $display("FAIL done_timeout_idle: got %0d want 0", bus.state_o); end
        bus.btn_stop_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask
`else
    task automatic test_beep_repeat();
        int d0;
        logic exp;
        enter_done_stop_zero();
        for (int n = 0; n < 15; n++) begin
            exp = ((n / 5) % 2) == 0;
            n_tests++;
            if (bus.beep !== exp) begin n_fail++; $display("FAIL beep_toggle[%0d]: got %b want %b", n, bus.beep, exp); end
            @(negedge clk);
        end
        bus.btn_stop_n = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++;
        if (bus.state_o !== ST_DONE) begin n_fail++; $display("FAIL done_no_timeout: got %0d want 3", bus.state_o); end
        d0 = c_dec;
        press(KEY_DN);
        n_tests++;
        if (bus.state_o !== ST_IDLE || bus.beep !== 1'b0 || c_dec - d0 !== 0) begin
            n_fail++; $display("FAIL dn_ack: got state %0d beep %b dec %0d want 0 0 0", bus.state_o, bus.beep, c_dec - d0);
        end
    endtask
`endif

    task automatic test_start_guards();
        bus.tmr_zero = 1'b0;
        bus.btn_start_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_start_n = 1'b1;
        repeat (15) @(negedge clk);
        n_tests++;
        if (bus.state_o !== ST_IDLE || bus.heater_on !== 1'b0) begin
            n_fail++; $display("FAIL glitch_start: got state %0d heater %b want 0 0", bus.state_o, bus.heater_on);
        end
        bus.door_open = 1'b1;
        repeat (12) @(negedge clk);
        press(KEY_START);
        n_tests++;
        if (bus.state_o !== ST_IDLE || bus.lamp_on !== 1'b1) begin
            n_fail++; $display("FAIL start_door_open: got state %0d lamp %b want 0 1", bus.state_o, bus.lamp_on);
        end
        bus.door_open = 1'b0;
        repeat (12) @(negedge clk);
        bus.tmr_zero = 1'b1;
        press(KEY_START);
        n_tests++;
        if (bus.state_o !== ST_IDLE || bus.lamp_on !== 1'b0) begin
            n_fail++; $display("FAIL start_at_zero: got state %0d lamp %b want 0 0", bus.state_o, bus.lamp_on);
        end
        bus.tmr_zero = 1'b0;
    endtask

    task automatic test_pause_clear();
        int l0;
        press(KEY_START);
        n_tests++;
        if (bus.state_o !== ST_COOK) begin n_fail++; $display("FAIL pc_cook: got %0d want 1", bus.state_o); end
        l0 = c_clr;
        press(KEY_STOP);
        n_tests++;
        if (bus.state_o !== ST_PAUSE || c_clr - l0 !== 0) begin
            n_fail++; $display("FAIL cook_stop_pause: got state %0d clr %0d want 2 0", bus.state_o, c_clr - l0);
        end
        press(KEY_STOP);
        n_tests++;
        if (bus.state_o !== ST_IDLE || c_clr - l0 !== 1) begin
            n_fail++; $display("FAIL pause_stop_clear: got state %0d clr %0d want 0 1", bus.state_o, c_clr - l0);
        end
    endtask

    task automatic test_reset_midcook();
        press(KEY_START);
        n_tests++;
        if (bus.heater_on !== 1'b1) begin n_fail++; $display("FAIL mid_cook_heater: got %b want 1", bus.heater_on); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.heater_on !== 1'b0 || bus.state_o !== ST_IDLE) begin
            n_fail++; $display("FAIL async_reset: got heater %b state %0d want 0 0", bus.heater_on, bus.state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus.state_o !== ST_IDLE) begin n_fail++; $display("FAIL post_reset_state: got %0d want 0", bus.state_o); end
    endtask

    task automatic test_pulse_rules();
        n_tests++;
        if (width_viol !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d want 0", width_viol); end
        n_tests++;
        if (excl_viol !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d want 0", excl_viol); end
    endtask

    initial begin
        bus.btn_start_n = 1'b1;
        bus.btn_stop_n  = 1'b1;
        bus.btn_up_n    = 1'b1;
        bus.btn_dn_n    = 1'b1;
        bus.door_open   = 1'b0;
        bus.tmr_zero    = 1'b0;
        test_reset();
        test_idle_keys();
        test_cook_ticks();
        test_door_pause();
`ifndef BEEP_REPEAT_EN
        test_done_beep();
`else
        test_beep_repeat();
`endif
        test_start_guards();
        test_pause_clear();
        test_reset_midcook();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
